// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch NOP encoding and the SRAM arbiter state encoding.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WR_SETUP = 2'd1,
        WR_PULSE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and MEM-stage loads/stores.
// Loads complete in the fetch cycle; stores take three cycles (setup, pulse, hold).
module mem_arbiter
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_addr,
    output logic [15:0] if_instr,
    output logic        ifkeep,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_busy,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_dout,
    input  logic [15:0] ram_din,
    output logic        ram_doe,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [15:0] stall_cnt
);

    arb_state_t          state;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    // State, latched store payload, glitch-free write strobe and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            ram_we_n  <= 1'b1;
            wr_addr   <= '0;
            wr_data   <= '0;
            stall_cnt <= '0;
        end else begin
            ram_we_n <= 1'b1;
            if (ifkeep) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            case (state)
                FETCH: begin
                    // A store wins over a simultaneous load.
                    if (mem_wr) begin
                        wr_addr  <= mem_addr;
                        wr_data  <= mem_wdata;
                        ram_we_n <= 1'b0;
                        state    <= WR_SETUP;
                    end
                end
                WR_SETUP: state <= WR_PULSE;
                WR_PULSE: state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    // Bus steering and pipeline handshakes; forced idle while reset is high.
    always_comb begin
        if_instr  = NOP_INSTR;
        ifkeep    = 1'b0;
        mem_busy  = 1'b0;
        mem_rdata = '0;
        ram_addr  = if_addr;
        ram_dout  = wr_data;
        ram_doe   = 1'b0;
        ram_oe_n  = 1'b1;
        if (!rst) begin
            case (state)
                FETCH: begin
                    if (mem_wr) begin
                        ram_addr = mem_addr;
                        ram_dout = mem_wdata;
                        ram_doe  = 1'b1;
                        ifkeep   = 1'b1;
                        mem_busy = 1'b1;
                    end else if (mem_rd) begin
                        ram_addr  = mem_addr;
                        ram_oe_n  = 1'b0;
                        mem_rdata = ram_din;
                        ifkeep    = 1'b1;
                    end else begin
                        ram_oe_n = 1'b0;
                        if_instr = ram_din;
                    end
                end
                WR_SETUP: begin
                    ram_addr = wr_addr;
                    ram_doe  = 1'b1;
                    ifkeep   = 1'b1;
                    mem_busy = 1'b1;
                end
                WR_PULSE: begin
                    ram_addr = wr_addr;
                    ram_doe  = 1'b1;
                    ifkeep   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-cycle expectations queued by the driver,
// compared at the falling edge against the DUT pins and a behavioural SRAM.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_addr;
    logic [15:0] if_instr;
    logic        ifkeep;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_busy;
    logic [15:0] ram_addr;
    logic [15:0] ram_dout;
    logic [15:0] ram_din;
    logic        ram_doe;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [15:0] stall_cnt;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_addr   (if_addr),
        .if_instr  (if_instr),
        .ifkeep    (ifkeep),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .ram_doe   (ram_doe),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] if_instr;
        logic        ifkeep;
        logic        mem_busy;
        logic [15:0] mem_rdata;
        logic [15:0] ram_addr;
        logic [15:0] ram_dout;
        logic        ram_oe_n;
        logic        ram_we_n;
        logic        ram_doe;
        logic [15:0] stall;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] exp_stall;
    logic [15:0] sram [logic [15:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] ii, input logic keep, input logic busy,
                                input logic [15:0] rdata, input logic [15:0] addr,
                                input logic [15:0] dout, input logic oe_n,
                                input logic we_n, input logic doe);
        exp_t e;
        e.if_instr  = ii;
        e.ifkeep    = keep;
        e.mem_busy  = busy;
        e.mem_rdata = rdata;
        e.ram_addr  = addr;
        e.ram_dout  = dout;
        e.ram_oe_n  = oe_n;
        e.ram_we_n  = we_n;
        e.ram_doe   = doe;
        e.stall     = 16'h0000;
        return e;
    endfunction

    // SRAM latches data on the rising edge of its write strobe.
    always @(posedge ram_we_n) begin
        if (rst === 1'b0 && ram_doe === 1'b1) begin
            sram[ram_addr] = ram_dout;
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("if_instr",  32'(if_instr),  32'(e.if_instr));
            check("ifkeep",    32'(ifkeep),    32'(e.ifkeep));
            check("mem_busy",  32'(mem_busy),  32'(e.mem_busy));
            check("mem_rdata", 32'(mem_rdata), 32'(e.mem_rdata));
            check("ram_addr",  32'(ram_addr),  32'(e.ram_addr));
            check("ram_oe_n",  32'(ram_oe_n),  32'(e.ram_oe_n));
            check("ram_we_n",  32'(ram_we_n),  32'(e.ram_we_n));
            check("ram_doe",   32'(ram_doe),   32'(e.ram_doe));
            if (e.ram_doe) begin
                check("ram_dout", 32'(ram_dout), 32'(e.ram_dout));
            end
            check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [15:0] maddr,
                         input logic [15:0] wdata, input logic [15:0] ifa,
                         input logic [15:0] din, input exp_t e_in);
        exp_t e;
        e         = e_in;
        mem_rd    = rd;
        mem_wr    = wr;
        mem_addr  = maddr;
        mem_wdata = wdata;
        if_addr   = ifa;
        ram_din   = din;
        e.stall   = exp_stall;
        sb.push_back(e);
        @(posedge clk);
        if (e.ifkeep) exp_stall = exp_stall + 16'd1;
        #1;
    endtask

    localparam logic [15:0] NOP = 16'h0800;

    initial begin
        rst       = 1'b1;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if_addr   = 16'h0000;
        ram_din   = 16'h0000;
        exp_stall = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ifkeep",   32'(ifkeep),    32'd0);
        check("rst_mem_busy", 32'(mem_busy),  32'd0);
        check("rst_if_instr", 32'(if_instr),  32'(NOP));
        check("rst_we_n",     32'(ram_we_n),  32'd1);
        check("rst_doe",      32'(ram_doe),   32'd0);
        check("rst_oe_n",     32'(ram_oe_n),  32'd1);
        check("rst_stall",    32'(stall_cnt), 32'd0);
        rst = 1'b0;

        // Plain fetch.
        drive(0, 0, 16'h0000, 16'h0000, 16'h0010, 16'h4E01,
              mk(16'h4E01, 0, 0, 16'h0000, 16'h0010, 16'h0000, 0, 1, 0));
        // Single-cycle load, then fetch resumes.
        drive(1, 0, 16'h8000, 16'h0000, 16'h0011, 16'h1234,
              mk(NOP, 1, 0, 16'h1234, 16'h8000, 16'h0000, 0, 1, 0));
        drive(0, 0, 16'h0000, 16'h0000, 16'h0011, 16'h4E02,
              mk(16'h4E02, 0, 0, 16'h0000, 16'h0011, 16'h0000, 0, 1, 0));

        // Store: payload changes in WR_PULSE to prove it was latched.
        drive(0, 1, 16'h9000, 16'hBEEF, 16'h0012, 16'h7777,
              mk(NOP, 1, 1, 16'h0000, 16'h9000, 16'hBEEF, 1, 1, 1));
        drive(0, 1, 16'h9000, 16'hBEEF, 16'h0012, 16'h7777,
              mk(NOP, 1, 1, 16'h0000, 16'h9000, 16'hBEEF, 1, 0, 1));
        drive(1, 0, 16'h1111, 16'h0000, 16'h0012, 16'h7777,
              mk(NOP, 1, 0, 16'h0000, 16'h9000, 16'hBEEF, 1, 1, 1));
        drive(0, 0, 16'h0000, 16'h0000, 16'h0012, 16'h4E03,
              mk(16'h4E03, 0, 0, 16'h0000, 16'h0012, 16'h0000, 0, 1, 0));
        check("sram_9000", 32'(sram[16'h9000]), 32'hBEEF);

        // Load and store together: store only, no load data.
        drive(1, 1, 16'hA000, 16'hCAFE, 16'h0013, 16'h5A5A,
              mk(NOP, 1, 1, 16'h0000, 16'hA000, 16'hCAFE, 1, 1, 1));
        drive(1, 1, 16'hA000, 16'hCAFE, 16'h0013, 16'h5A5A,
              mk(NOP, 1, 1, 16'h0000, 16'hA000, 16'hCAFE, 1, 0, 1));
        drive(1, 1, 16'hA000, 16'hCAFE, 16'h0013, 16'h5A5A,
              mk(NOP, 1, 0, 16'h0000, 16'hA000, 16'hCAFE, 1, 1, 1));
        drive(0, 0, 16'h0000, 16'h0000, 16'h0013, 16'h4E04,
              mk(16'h4E04, 0, 0, 16'h0000, 16'h0013, 16'h0000, 0, 1, 0));
        check("sram_A000", 32'(sram[16'hA000]), 32'hCAFE);

        // Reset pulse during WR_SETUP aborts the write without a clock edge.
        drive(0, 1, 16'hB000, 16'h5555, 16'h0014, 16'h0000,
              mk(NOP, 1, 1, 16'h0000, 16'hB000, 16'h5555, 1, 1, 1));
        begin
            exp_t e;
            e       = mk(NOP, 1, 1, 16'h0000, 16'hB000, 16'h5555, 1, 0, 1);
            e.stall = exp_stall;
            sb.push_back(e);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_we_n",   32'(ram_we_n),  32'd1);
        check("abort_doe",    32'(ram_doe),   32'd0);
        check("abort_oe_n",   32'(ram_oe_n),  32'd1);
        check("abort_ifkeep", 32'(ifkeep),    32'd0);
        check("abort_stall",  32'(stall_cnt), 32'd0);
        mem_wr = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_stall = 16'h0000;
        drive(0, 0, 16'h0000, 16'h0000, 16'h0020, 16'h1357,
              mk(16'h1357, 0, 0, 16'h0000, 16'h0020, 16'h0000, 0, 1, 0));
        check("abort_no_write", 32'(sram.exists(16'hB000)), 32'd0);

        // Counter wrap: 0xFFFF unchecked load cycles, then one checked load.
        mem_rd   = 1'b1;
        mem_addr = 16'h4000;
        ram_din  = 16'h2468;
        repeat (65535) @(posedge clk);
        exp_stall = exp_stall + 16'hFFFF;
        #1;
        drive(1, 0, 16'h4000, 16'h0000, 16'h0021, 16'h2468,
              mk(NOP, 1, 0, 16'h2468, 16'h4000, 16'h0000, 0, 1, 0));
        drive(0, 0, 16'h0000, 16'h0000, 16'h0021, 16'h4E05,
              mk(16'h4E05, 0, 0, 16'h0000, 16'h0021, 16'h0000, 0, 1, 0));
        check("wrap_model", 32'(exp_stall), 32'd0);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and asynchronous active-high reset; ports are named clk and rst.
REQ-002 Ports SHALL be:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- if_addr  in  16  PC-driven fetch address
- if_instr  out  16  fetched instruction to IF/ID
- ifkeep  out  1  1 = IF/ID and PC hold (stall fetch)
- mem_rd  in  1  MEM-stage load request
- mem_wr  in  1  MEM-stage store request
- mem_addr  in  16  load/store address
- mem_wdata  in  16  store data
- mem_rdata  out  16  load data
- mem_busy  out  1  1 = MEM stage and upstream hold this cycle
- ram_addr  out  16  SRAM address
- ram_dout  out  16  SRAM write data
- ram_din  in  16  SRAM read data
- ram_doe  out  1  1 = drive SRAM data bus
- ram_oe_n  out  1  SRAM output enable, active low
- ram_we_n  out  1  SRAM write enable, active low
- stall_cnt  out  16  count of cycles with ifkeep=1

Function
REQ-003 The block SHALL arbitrate one single-port SRAM between instruction fetch and MEM-stage data access, with data access having priority.
REQ-004 The block SHALL implement FSM states FETCH, WR_SETUP and WR_PULSE.
REQ-005 In FETCH with mem_rd=0 and mem_wr=0, the block SHALL drive:
- ram_addr=if_addr, ram_oe_n=0, ram_we_n=1, ram_doe=0
- if_instr=ram_din, ifkeep=0, mem_busy=0
REQ-006 In FETCH with mem_rd=1 and mem_wr=0, the block SHALL complete the load combinationally in the same cycle:
- ram_addr=mem_addr, ram_oe_n=0, mem_rdata=ram_din
- ifkeep=1, if_instr=0x0800 (NOP), mem_busy=0
- state stays FETCH
REQ-007 In FETCH with mem_wr=1, the block SHALL:
- drive ram_addr=mem_addr, ram_dout=mem_wdata, ram_doe=1, ram_oe_n=1, ram_we_n=1
- drive ifkeep=1, mem_busy=1, if_instr=0x0800
- register mem_addr/mem_wdata and move to WR_SETUP.
REQ-008 In WR_SETUP the block SHALL hold the registered address and data, ram_doe=1, ram_we_n=0, ifkeep=1, mem_busy=1, and move to WR_PULSE.
REQ-009 In WR_PULSE the block SHALL hold address and data, ram_doe=1, ram_we_n=1 (hold time), ifkeep=1, mem_busy=0, and return to FETCH; a store therefore occupies 3 cycles.
REQ-010 When mem_rd and mem_wr are both 1, the block SHALL treat the request as a store and ignore mem_rd.
REQ-011 In WR_SETUP and WR_PULSE, mem_rd and mem_wr SHALL be ignored.
REQ-012 ram_we_n SHALL be registered (glitch-free); other outputs may be combinational from state and inputs.
REQ-013 stall_cnt SHALL increment by 1 on every posedge where ifkeep=1, wrapping 0xFFFF->0x0000.
REQ-014 mem_rdata SHALL equal 0x0000 in all cycles other than REQ-006 loads.

Reset
REQ-015 While rst=1, asynchronously:
- state=FETCH, ram_we_n=1, ram_doe=0, ram_oe_n=1
- stall_cnt=0, ifkeep=0, mem_busy=0, if_instr=0x0800
REQ-016 Reset asserted mid-store SHALL abort the write immediately with ram_we_n=1; the partial write is not retried.

Structure
REQ-017 The shared package cpu_pkg SHALL hold NOP_INSTR (16'h0800) and the FSM state encoding; the block SHALL have no sub-modules.

Verification
REQ-018 The bench SHALL cover:
- Reset release, no requests, if_addr=0x0010, ram_din=0x4E01 -> if_instr=0x4E01, ifkeep=0, ram_oe_n=0, stall_cnt=0.
- Load: mem_rd=1, mem_addr=0x8000, ram_din=0x1234 -> same cycle mem_rdata=0x1234, ram_addr=0x8000, ifkeep=1, if_instr=0x0800; stall_cnt=1 after the edge.
- Store: mem_wr=1, addr=0x9000, wdata=0xBEEF -> three cycles ifkeep=1; ram_we_n low only in the WR_SETUP cycle; mem_busy=1,1,0; address and data stable all three cycles; SRAM model holds 0xBEEF.
- Simultaneous mem_rd=1 and mem_wr=1 -> store sequence only; mem_rdata=0.
- rst pulse during WR_SETUP -> ram_we_n=1 and ram_doe=0 without waiting for a clock edge; state FETCH after release.
- stall_cnt preset near wrap via 0xFFFF stall cycles, then one more load -> stall_cnt=0x0000.
